// File: rtl/core_pkg.sv
// Shared core types and sizing for the rename stage and its RAT storage.
package core_pkg;
  localparam int PREGS     = 64;
  localparam int ARCH_REGS = 32;
  localparam int ZERO_REG  = 31;
  localparam int PTAG_W    = $clog2(PREGS);

  typedef logic [PTAG_W-1:0] phys_t;
  typedef logic [4:0]        arch_t;
  typedef logic [ARCH_REGS-1:0][PTAG_W-1:0] rat_t;

  function automatic phys_t identity_tag(input int idx);
    return phys_t'(idx);
  endfunction
endpackage

// File: rtl/rat_array.sv
// 32-entry arch->phys map: three async read ports, one write port and a bulk load.
// Entry ZERO_REG is a constant; writes and loads to it are ignored.
module rat_array
  import core_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  arch_t rd_addr_a,
  input  arch_t rd_addr_b,
  input  arch_t rd_addr_c,
  output phys_t rd_data_a,
  output phys_t rd_data_b,
  output phys_t rd_data_c,
  input  logic  wr_en,
  input  arch_t wr_addr,
  input  phys_t wr_data,
  input  logic  load_en,
  input  rat_t  load_data,
  output rat_t  rat_state
);

  genvar gi;
  generate
    for (gi = 0; gi < ARCH_REGS; gi++) begin : g_entry
      if (gi == ZERO_REG) begin : g_zero
        assign rat_state[gi] = identity_tag(ZERO_REG);
      end else begin : g_flop
        phys_t entry_reg;
        // Bulk load wins over the single write so a flush fully replaces state.
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            entry_reg <= identity_tag(gi);
          end else if (load_en) begin
            entry_reg <= load_data[gi];
          end else if (wr_en && (wr_addr == arch_t'(gi))) begin
            entry_reg <= wr_data;
          end
        end
        assign rat_state[gi] = entry_reg;
      end
    end
  endgenerate

  assign rd_data_a = rat_state[rd_addr_a];
  assign rd_data_b = rat_state[rd_addr_b];
  assign rd_data_c = rat_state[rd_addr_c];

endmodule

// File: rtl/rename_rat.sv
// Single-wide rename: speculative + committed RAT, free-list pop handshake and a
// registered output stage towards dispatch/ROB.
module rename_rat
  import core_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  ren_valid,
  output logic  ren_ready,
  input  arch_t ren_rs1_arch,
  input  arch_t ren_rs2_arch,
  input  arch_t ren_rd_arch,
  input  logic  ren_rd_wr,
  output logic  fl_alloc_en,
  input  phys_t fl_alloc_phys,
  input  logic  fl_alloc_valid,
  output logic  out_valid,
  input  logic  out_ready,
  output phys_t out_rs1_phys,
  output phys_t out_rs2_phys,
  output phys_t out_rd_phys,
  output phys_t out_old_rd_phys,
  output logic  out_rd_alloc,
  input  logic  cm_en,
  input  arch_t cm_rd_arch,
  input  phys_t cm_rd_phys,
  input  logic  flush
);

  logic  need_alloc;
  logic  fire;
  phys_t spec_rs1;
  phys_t spec_rs2;
  phys_t spec_rd;
  rat_t  spec_state;
  rat_t  commit_state;
  rat_t  flush_load;
  phys_t commit_rd_a;
  phys_t commit_rd_b;
  phys_t commit_rd_c;

  assign need_alloc  = ren_rd_wr && (ren_rd_arch != arch_t'(ZERO_REG));
  assign ren_ready   = !flush && (!out_valid || out_ready) && (!need_alloc || fl_alloc_valid);
  assign fire        = ren_valid && ren_ready;
  assign fl_alloc_en = fire && need_alloc;

  // Restore image: committed map with this cycle's commit folded in.
  always_comb begin
    flush_load = commit_state;
    if (cm_en) begin
      flush_load[cm_rd_arch] = cm_rd_phys;
    end
  end

  rat_array u_spec_rat (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_a (ren_rs1_arch),
    .rd_addr_b (ren_rs2_arch),
    .rd_addr_c (ren_rd_arch),
    .rd_data_a (spec_rs1),
    .rd_data_b (spec_rs2),
    .rd_data_c (spec_rd),
    .wr_en     (fl_alloc_en),
    .wr_addr   (ren_rd_arch),
    .wr_data   (fl_alloc_phys),
    .load_en   (flush),
    .load_data (flush_load),
    .rat_state (spec_state)
  );

  rat_array u_commit_rat (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_a (cm_rd_arch),
    .rd_addr_b (ren_rs1_arch),
    .rd_addr_c (ren_rs2_arch),
    .rd_data_a (commit_rd_a),
    .rd_data_b (commit_rd_b),
    .rd_data_c (commit_rd_c),
    .wr_en     (cm_en),
    .wr_addr   (cm_rd_arch),
    .wr_data   (cm_rd_phys),
    .load_en   (1'b0),
    .load_data (spec_state),
    .rat_state (commit_state)
  );

  // RAT write and output capture share one edge, so a dependent in the next
  // cycle already reads the new tag without any bypass.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid       <= 1'b0;
      out_rs1_phys    <= '0;
      out_rs2_phys    <= '0;
      out_rd_phys     <= '0;
      out_old_rd_phys <= '0;
      out_rd_alloc    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid       <= 1'b1;
      out_rs1_phys    <= spec_rs1;
      out_rs2_phys    <= spec_rs2;
      out_old_rd_phys <= spec_rd;
      out_rd_phys     <= need_alloc ? fl_alloc_phys : spec_rd;
      out_rd_alloc    <= need_alloc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
